// File: rtl/io_ctc16.sv
// io_ctc16: two-channel 16-bit counter/timer mapped into the CPU I/O window.
// Each channel is a timer (ticks every clock) or an event counter (ticks on a
// synchronized rising edge of pulse_in). It sets a done flag and drives an
// active-low one-cycle cout pulse on terminal count.
module io_ctc16 #(
  parameter logic [5:0] BASE = 6'b100010
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        IORead,
  input  logic        IOWrite,
  input  logic [9:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic [1:0]  pulse_in,
  output logic [1:0]  cout
);

  localparam int unsigned CW  = 16;
  localparam int unsigned NCH = 2;
  localparam int unsigned MW  = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Per-channel architectural state
  state_t          r_state    [NCH];
  logic [MW-1:0]   r_mode     [NCH];
  logic [CW-1:0]   r_init     [NCH];
  logic [CW-1:0]   r_count    [NCH];
  logic [NCH-1:0]  r_done;
  logic [NCH-1:0]  r_cout;

  // Next-state values
  state_t          w_state_nx [NCH];
  logic [MW-1:0]   w_mode_nx  [NCH];
  logic [CW-1:0]   w_init_nx  [NCH];
  logic [CW-1:0]   w_count_nx [NCH];
  logic [NCH-1:0]  w_done_nx;
  logic [NCH-1:0]  w_cout_nx;

  // pulse_in synchronizer and edge-detect flops
  logic [NCH-1:0]  r_sync1;
  logic [NCH-1:0]  r_sync2;
  logic [NCH-1:0]  r_sync3;

  // Decode and tick qualifiers
  logic            w_sel;
  logic [3:0]      w_off;
  logic [NCH-1:0]  w_rise;
  logic [NCH-1:0]  w_tick;
  logic [NCH-1:0]  w_term;
  logic [NCH-1:0]  w_wr_mode;
  logic [NCH-1:0]  w_wr_init;
  logic [NCH-1:0]  w_rd_stat;

  assign w_sel  = (addr[9:4] == BASE);
  assign w_off  = addr[3:0];
  assign w_rise = r_sync2 & ~r_sync3;
  assign cout   = r_cout;

  // Register-window decode and per-channel tick source select
  always_comb begin
    w_wr_mode = '0;
    w_wr_init = '0;
    w_rd_stat = '0;
    w_tick    = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      w_wr_mode[i] = IOWrite & w_sel & (w_off == 4'(2 * i));
      w_wr_init[i] = IOWrite & w_sel & (w_off == 4'(4 + 2 * i));
      w_rd_stat[i] = IORead  & w_sel & (w_off == 4'(2 * i));
      w_tick[i]    = r_mode[i][0] ? w_rise[i] : 1'b1;
    end
  end

  // Two-flop synchronizer plus a third flop for rising-edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= pulse_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Channel state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NCH); i++) begin
        r_state[i] <= S_IDLE;
        r_mode[i]  <= '0;
        r_init[i]  <= '0;
        r_count[i] <= '0;
      end
      r_done <= '0;
      r_cout <= '1;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        r_state[i] <= w_state_nx[i];
        r_mode[i]  <= w_mode_nx[i];
        r_init[i]  <= w_init_nx[i];
        r_count[i] <= w_count_nx[i];
      end
      r_done <= w_done_nx;
      r_cout <= w_cout_nx;
    end
  end

  // Channel next-state: countdown first, CPU writes override it
  always_comb begin
    for (int i = 0; i < int'(NCH); i++) begin
      w_state_nx[i] = r_state[i];
      w_mode_nx[i]  = r_mode[i];
      w_init_nx[i]  = r_init[i];
      w_count_nx[i] = r_count[i];
    end
    w_term    = '0;
    w_done_nx = r_done;
    w_cout_nx = '1;

    for (int i = 0; i < int'(NCH); i++) begin
      case (r_state[i])
        S_RUN: begin
          if (w_tick[i]) begin
            if (r_count[i] == CW'(1)) begin
              w_term[i] = 1'b1;
              if (r_mode[i][1]) begin
                w_count_nx[i] = r_init[i];
              end else begin
                w_count_nx[i] = '0;
                w_state_nx[i] = S_IDLE;
              end
            end else begin
              w_count_nx[i] = r_count[i] - CW'(1);
            end
          end
        end
        default: begin
        end
      endcase

      // A mode write stops the channel and freezes the count where it is
      if (w_wr_mode[i]) begin
        w_mode_nx[i]  = wdata[MW-1:0];
        w_state_nx[i] = S_IDLE;
        w_count_nx[i] = r_count[i];
        w_term[i]     = 1'b0;
      end else if (w_wr_init[i]) begin
        // An init write (re)loads the count; zero leaves the channel idle
        w_init_nx[i]  = wdata;
        w_count_nx[i] = wdata;
        w_state_nx[i] = (wdata != '0) ? S_RUN : S_IDLE;
        w_term[i]     = 1'b0;
      end

      // Terminal event wins over a same-edge status-read clear
      w_done_nx[i] = w_term[i] | (r_done[i] & ~w_rd_stat[i]);
      w_cout_nx[i] = ~w_term[i];
    end
  end

  // Combinational load data for the CPU, zero when not addressed
  always_comb begin
    rdata = '0;
    if (IORead && w_sel) begin
      case (w_off)
        4'h0:    rdata = {14'd0, (r_state[0] == S_RUN), r_done[0]};
        4'h2:    rdata = {14'd0, (r_state[1] == S_RUN), r_done[1]};
        4'h4:    rdata = r_count[0];
        4'h6:    rdata = r_count[1];
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_ctc16.sv
// tb_io_ctc16: directed and randomized checks of io_ctc16 against a
// closed-form model of the timer/counter behaviour.
module tb_io_ctc16;

  logic        clock = 1'b0;
  logic        reset;
  logic        IORead;
  logic        IOWrite;
  logic [9:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [1:0]  pulse_in;
  logic [1:0]  cout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  localparam logic [9:0] A_MODE0 = 10'h220;
  localparam logic [9:0] A_MODE1 = 10'h222;
  localparam logic [9:0] A_INIT0 = 10'h224;
  localparam logic [9:0] A_INIT1 = 10'h226;

  io_ctc16 dut (
    .clock    (clock),
    .reset    (reset),
    .IORead   (IORead),
    .IOWrite  (IOWrite),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .pulse_in (pulse_in),
    .cout     (cout)
  );

  always #5 clock = ~clock;

  // Edge index: after step() returns, cyc names the edge just taken
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One-cycle store: acts on the next edge only
  task automatic wr(input logic [9:0] a, input logic [15:0] d);
    IOWrite = 1'b1;
    addr    = a;
    wdata   = d;
    step();
    IOWrite = 1'b0;
    addr    = '0;
    wdata   = '0;
  endtask

  // One-cycle load: samples rdata, then lets the edge apply side effects
  task automatic rd(input logic [9:0] a, output logic [15:0] v);
    IORead = 1'b1;
    addr   = a;
    #1;
    v = rdata;
    step();
    IORead = 1'b0;
    addr   = '0;
  endtask

  // Look at rdata without letting a clock edge see the strobe
  task automatic peek(input logic [9:0] a, output logic [15:0] v);
    IORead = 1'b1;
    addr   = a;
    #1;
    v = rdata;
    IORead = 1'b0;
    addr   = '0;
  endtask

  // Timer model: dt edges after loading n
  function automatic int tmr_cnt(input int n, input bit rep, input int dt);
    if (rep) return n - (dt % n);
    return (dt < n) ? n - dt : 0;
  endfunction

  function automatic bit tmr_term(input int n, input bit rep, input int dt);
    if (dt <= 0) return 1'b0;
    return rep ? ((dt % n) == 0) : (dt == n);
  endfunction

  task automatic timer_trial(input int ch, input int n, input bit rep, input int len);
    logic [9:0]  a_mode;
    logic [9:0]  a_init;
    logic [15:0] v;
    logic [1:0]  exp_cout;
    int          e;
    int          dt;
    a_mode = (ch != 0) ? A_MODE1 : A_MODE0;
    a_init = (ch != 0) ? A_INIT1 : A_INIT0;
    wr(a_mode, {14'd0, rep, 1'b0});
    rd(a_mode, v);
    wr(a_init, 16'(n));
    e = cyc;
    for (int k = 0; k < len; k++) begin
      dt = cyc - e;
      peek(a_init, v);
      chk("tmr_count", 32'(v), 32'(tmr_cnt(n, rep, dt)));
      exp_cout = 2'b11;
      if (tmr_term(n, rep, dt)) exp_cout[ch] = 1'b0;
      chk("tmr_cout", 32'(cout), 32'(exp_cout));
      step();
    end
    dt = cyc - e;
    rd(a_mode, v);
    chk("tmr_status", 32'(v), {30'd0, (rep || dt < n), (dt >= n)});
    if (tmr_term(n, rep, cyc + 1 - e)) step();
    wr(a_mode, 16'd0);
  endtask

  // Counter model on ch0: each rise seen at cycle c is counted at edge c+3
  task automatic cnt_run(input int k, input bit lev[$]);
    logic [15:0] v;
    logic [1:0]  exp_cout;
    int          ticks[$];
    int          c;
    int          nt;
    bit          prev;
    prev = 1'b0;
    wr(A_MODE0, 16'd1);
    rd(A_MODE0, v);
    wr(A_INIT0, 16'(k));
    for (int j = 0; j < lev.size(); j++) begin
      c = cyc;
      pulse_in[0] = lev[j];
      if (lev[j] && !prev) ticks.push_back(c + 3);
      prev = lev[j];
      nt = 0;
      foreach (ticks[m]) if (ticks[m] <= c) nt++;
      peek(A_INIT0, v);
      chk("cnt_count", 32'(v), 32'((nt >= k) ? 0 : k - nt));
      exp_cout = 2'b11;
      if (ticks.size() >= k && ticks[k-1] == c) exp_cout[0] = 1'b0;
      chk("cnt_cout", 32'(cout), 32'(exp_cout));
      step();
    end
    pulse_in[0] = 1'b0;
    rd(A_MODE0, v);
    chk("cnt_status", 32'(v), 32'd1);
  endtask

  initial begin
    logic [15:0] v;
    bit          lev[$];
    int          e;
    int          n;
    int          k;
    bit          rep;

    reset    = 1'b0;
    IORead   = 1'b0;
    IOWrite  = 1'b0;
    addr     = '0;
    wdata    = '0;
    pulse_in = '0;
    repeat (3) step();

    // Reset state
    peek(A_MODE0, v); chk("rst_stat0", 32'(v), 32'd0);
    peek(A_INIT1, v); chk("rst_cnt1", 32'(v), 32'd0);
    chk("rst_cout", 32'(cout), 32'd3);
    reset = 1'b1;
    step();

    // One-shot timer on ch0, init 5
    wr(A_MODE0, 16'd0);
    wr(A_INIT0, 16'd5);
    for (int i = 0; i < 5; i++) begin
      chk("os_cout_hi", 32'(cout), 32'd3);
      rd(A_INIT0, v);
      chk("os_count", 32'(v), 32'(5 - i));
    end
    chk("os_cout_lo", 32'(cout), 32'd2);
    step();
    chk("os_cout_back", 32'(cout), 32'd3);
    rd(A_MODE0, v); chk("os_status", 32'(v), 32'd1);
    rd(A_MODE0, v); chk("os_status_clr", 32'(v), 32'd0);

    // Repeating timer on ch1, period 3
    wr(A_MODE1, 16'd2);
    wr(A_INIT1, 16'd3);
    e = cyc;
    for (int i = 0; i < 10; i++) begin
      chk("rep_cout", 32'(cout), tmr_term(3, 1'b1, cyc - e) ? 32'd1 : 32'd3);
      step();
    end
    rd(A_MODE1, v); chk("rep_status", 32'(v), 32'd3);
    peek(A_MODE1, v); chk("rep_status_clr", 32'(v), 32'd2);
    if (tmr_term(3, 1'b1, cyc + 1 - e)) step();
    wr(A_MODE1, 16'd0);

    // Event counter on ch0: two clean pulses, then a glitch plus a pulse
    lev = '{0,0,1,1,1,0,0,0,1,1,1,0,0,0,0,0,0};
    cnt_run(2, lev);
    lev = '{0,0,1,0,0,0,0,0,1,1,1,0,0,0,0,0,0};
    cnt_run(2, lev);

    // Status read landing on the terminal edge keeps done set
    wr(A_MODE0, 16'd0);
    rd(A_MODE0, v);
    wr(A_INIT0, 16'd3);
    step();
    step();
    rd(A_MODE0, v); chk("same_edge_pre", 32'(v), 32'd2);
    peek(A_MODE0, v); chk("same_edge_done", 32'(v), 32'd1);
    chk("same_edge_cout", 32'(cout), 32'd2);

    // Init of zero never starts the channel
    wr(A_MODE1, 16'd0);
    rd(A_MODE1, v);
    wr(A_INIT1, 16'd0);
    for (int i = 0; i < 3; i++) begin
      peek(A_MODE1, v); chk("init0_status", 32'(v), 32'd0);
      peek(A_INIT1, v); chk("init0_count", 32'(v), 32'd0);
      chk("init0_cout", 32'(cout), 32'd3);
      step();
    end

    // Accesses outside the window or to unmapped offsets
    wr(A_INIT1, 16'd100);
    e = cyc;
    peek(10'h026, v); chk("bad_base_rd", 32'(v), 32'd0);
    peek(10'h236, v); chk("bad_base_rd2", 32'(v), 32'd0);
    peek(10'h228, v); chk("off8_rd", 32'(v), 32'd0);
    wr(10'h024, 16'd7);
    wr(10'h022, 16'd0);
    wr(10'h228, 16'd5);
    peek(A_INIT0, v); chk("bad_wr_cnt0", 32'(v), 32'd0);
    peek(A_MODE0, v); chk("bad_wr_stat0", 32'(v), 32'd1);
    peek(A_MODE1, v); chk("bad_wr_stat1", 32'(v), 32'd2);
    peek(A_INIT1, v); chk("bad_wr_cnt1", 32'(v), 32'(tmr_cnt(100, 1'b0, cyc - e)));
    wr(A_MODE1, 16'd0);
    rd(A_MODE0, v);

    // Randomized timer trials
    for (int t = 0; t < 6; t++) begin
      n   = $urandom_range(20, 2);
      rep = 1'($urandom_range(1, 0));
      timer_trial($urandom_range(1, 0), n, rep, $urandom_range(3 * n, 1));
    end

    // Randomized counter trials with legal pulse widths
    for (int t = 0; t < 3; t++) begin
      k = $urandom_range(4, 1);
      lev.delete();
      repeat (2) lev.push_back(1'b0);
      for (int p = 0; p < k; p++) begin
        repeat ($urandom_range(4, 2)) lev.push_back(1'b1);
        repeat ($urandom_range(4, 2)) lev.push_back(1'b0);
      end
      repeat (4) lev.push_back(1'b0);
      cnt_run(k, lev);
    end

    // Asynchronous reset in the middle of a long count
    wr(A_MODE0, 16'd0);
    wr(A_INIT0, 16'h1234);
    repeat (3) step();
    peek(A_INIT0, v); chk("pre_rst_count", 32'(v), 32'h1231);
    #2;
    reset = 1'b0;
    #1;
    peek(A_INIT0, v); chk("arst_cnt0", 32'(v), 32'd0);
    peek(A_MODE0, v); chk("arst_stat0", 32'(v), 32'd0);
    peek(A_INIT1, v); chk("arst_cnt1", 32'(v), 32'd0);
    peek(A_MODE1, v); chk("arst_stat1", 32'(v), 32'd0);
    chk("arst_cout", 32'(cout), 32'd3);
    step();
    step();
    reset = 1'b1;
    repeat (3) step();
    peek(A_INIT0, v); chk("post_rst_cnt0", 32'(v), 32'd0);
    peek(A_MODE0, v); chk("post_rst_stat0", 32'(v), 32'd0);
    chk("post_rst_cout", 32'(cout), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
